// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline sequencer for the rvseed IFU->IDU->EXU chain.
//   Issues the fetch enable, stalls ID for one cycle on a load-use hazard,
//   flushes ID/EX after an EXU redirect, and freezes the pipe while a
//   data-memory access waits for its ack. A timeout on that wait raises mem_err.
//   State and counters are registered; all outputs are combinational from
//   state and inputs.
//
// Optional feature macro: HAZ_PERF_CNT_EN adds saturating perf counters
//   stall_cyc (cycles with id_hold=1) and flush_cyc (cycles with id_flush=1).
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   enable         core run enable
//   id_vld/id_rs1/id_rs2/id_rs_use   ID instruction and its source usage
//   ex_vld/ex_mem_ren/ex_reg_wen/ex_rd  EX instruction (load / writeback)
//   ex_redirect    branch taken / jump pulse from EXU
//   mem_req/mem_ack data-memory handshake
//   fetch_en, id_hold, id_flush, ex_bubble, ex_hold  pipeline controls
//   mem_err        memory timeout error (held while in ERR)
//   state_o        FSM state for debug (IDLE=0 RUN=1 FLUSH=2 MEM_WAIT=3 ERR=4)
//   stall_cyc, flush_cyc  perf counters (HAZ_PERF_CNT_EN only)

module pipe_hazard_ctrl #(
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter int unsigned CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              id_vld,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [1:0]        id_rs_use,
  input  logic              ex_vld,
  input  logic              ex_mem_ren,
  input  logic              ex_reg_wen,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_redirect,
  input  logic              mem_req,
  input  logic              mem_ack,
  output logic              fetch_en,
  output logic              id_hold,
  output logic              id_flush,
  output logic              ex_bubble,
  output logic              ex_hold,
  output logic              mem_err,
  output logic [2:0]        state_o
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cyc,
  output logic [CNT_W-1:0]  flush_cyc
`endif
);

  localparam int unsigned FC_W = $clog2(FLUSH_CYCLES + 1);
  localparam int unsigned WC_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RUN      = 3'd1,
    S_FLUSH    = 3'd2,
    S_MEM_WAIT = 3'd3,
    S_ERR      = 3'd4
  } state_e;

  // Reject configurations the counters cannot represent.
  if (REG_AW == 0 || FLUSH_CYCLES == 0 || MEM_TIMEOUT == 0 || CNT_W == 0) begin : g_bad_params
    $error("pipe_hazard_ctrl: parameters must all be >= 1");
  end

  state_e            state_q, state_d;
  logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic              load_use;

  // Load in EX whose rd feeds a used source operand of the ID instruction.
  assign load_use = id_vld && ex_vld && ex_mem_ren && ex_reg_wen && (ex_rd != '0) &&
                    ((id_rs_use[0] && (id_rs1 == ex_rd)) ||
                     (id_rs_use[1] && (id_rs2 == ex_rd)));

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  // Next-state and pipeline-control decode.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    fetch_en    = 1'b0;
    id_hold     = 1'b0;
    id_flush    = 1'b0;
    ex_bubble   = 1'b0;
    ex_hold     = 1'b0;
    mem_err     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_RUN;
      end

      S_RUN: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (mem_req && !mem_ack) begin
          // A redirect seen together with a pending access is re-presented later.
          id_hold    = 1'b1;
          ex_hold    = 1'b1;
          wait_cnt_d = WC_W'(1);
          state_d    = S_MEM_WAIT;
        end else if (ex_redirect) begin
          id_flush    = 1'b1;
          ex_bubble   = 1'b1;
          flush_cnt_d = FC_W'(FLUSH_CYCLES);
          state_d     = S_FLUSH;
        end else if (load_use) begin
          // One bubble is enough: the load leaves EX at the next edge.
          id_hold   = 1'b1;
          ex_bubble = 1'b1;
        end else begin
          fetch_en = 1'b1;
        end
      end

      S_FLUSH: begin
        if (!enable) begin
          flush_cnt_d = '0;
          state_d     = S_IDLE;
        end else begin
          id_flush  = 1'b1;
          ex_bubble = 1'b1;
          if (flush_cnt_q <= FC_W'(1)) begin
            flush_cnt_d = '0;
            state_d     = S_RUN;
          end else begin
            flush_cnt_d = flush_cnt_q - FC_W'(1);
          end
        end
      end

      S_MEM_WAIT: begin
        // The access completes even if enable drops meanwhile.
        if (mem_ack) begin
          wait_cnt_d = '0;
          state_d    = enable ? S_RUN : S_IDLE;
        end else begin
          id_hold = 1'b1;
          ex_hold = 1'b1;
          if (wait_cnt_q >= WC_W'(MEM_TIMEOUT)) begin
            wait_cnt_d = '0;
            state_d    = S_ERR;
          end else begin
            wait_cnt_d = wait_cnt_q + WC_W'(1);
          end
        end
      end

      S_ERR: begin
        mem_err = 1'b1;
        id_hold = 1'b1;
        ex_hold = 1'b1;
        if (!enable) state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign state_o = state_q;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cyc_q;
  logic [CNT_W-1:0] flush_cyc_q;

  // Saturating stall / flush cycle counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cyc_q <= '0;
      flush_cyc_q <= '0;
    end else begin
      if (id_hold && (stall_cyc_q != {CNT_W{1'b1}})) stall_cyc_q <= stall_cyc_q + CNT_W'(1);
      if (id_flush && (flush_cyc_q != {CNT_W{1'b1}})) flush_cyc_q <= flush_cyc_q + CNT_W'(1);
    end
  end

  assign stall_cyc = stall_cyc_q;
  assign flush_cyc = flush_cyc_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned FLUSH_CYCLES = 2;
  localparam int unsigned MEM_TIMEOUT = 8;
  localparam int unsigned CNT_W = 2;
  localparam int PERF_MAX = (1 << CNT_W) - 1;

  // Expected-vector layout: {fetch, id_hold, id_flush, ex_bubble, ex_hold, mem_err, state[2:0]}
  localparam logic [8:0] V_IDLE     = 9'b000000_000;
  localparam logic [8:0] V_RUN      = 9'b100000_001;
  localparam logic [8:0] V_RUN_OFF  = 9'b000000_001;
  localparam logic [8:0] V_LU       = 9'b010100_001;
  localparam logic [8:0] V_REDIR    = 9'b001100_001;
  localparam logic [8:0] V_MEMREQ   = 9'b010010_001;
  localparam logic [8:0] V_FLUSH    = 9'b001100_010;
  localparam logic [8:0] V_WAIT     = 9'b010010_011;
  localparam logic [8:0] V_WAIT_ACK = 9'b000000_011;
  localparam logic [8:0] V_ERR      = 9'b010011_100;

  logic clk = 1'b0;
  logic rst_n;
  logic enable, id_vld, ex_vld, ex_mem_ren, ex_reg_wen, ex_redirect, mem_req, mem_ack;
  logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd;
  logic [1:0] id_rs_use;
  logic fetch_en, id_hold, id_flush, ex_bubble, ex_hold, mem_err;
  logic [2:0] state_o;
  logic [CNT_W-1:0] stall_cyc, flush_cyc;
  logic [8:0] obs;

  int n_tests = 0;
  int n_fail = 0;

  // Reference model: abstract pipeline mode plus remaining-flush / waited counts.
  int ms = 0;
  int m_flush_left = 0;
  int m_waited = 0;
  int m_stall = 0;
  int m_flushc = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .REG_AW(REG_AW), .FLUSH_CYCLES(FLUSH_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .id_vld(id_vld), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs_use(id_rs_use),
    .ex_vld(ex_vld), .ex_mem_ren(ex_mem_ren), .ex_reg_wen(ex_reg_wen), .ex_rd(ex_rd),
    .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ack(mem_ack),
    .fetch_en(fetch_en), .id_hold(id_hold), .id_flush(id_flush), .ex_bubble(ex_bubble),
    .ex_hold(ex_hold), .mem_err(mem_err), .state_o(state_o)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cyc(stall_cyc), .flush_cyc(flush_cyc)
`endif
  );

`ifndef HAZ_PERF_CNT_EN
  assign stall_cyc = '0;
  assign flush_cyc = '0;
`endif

  assign obs = {fetch_en, id_hold, id_flush, ex_bubble, ex_hold, mem_err, state_o};

  function automatic logic [8:0] model_out();
    logic f, h, fl, b, eh, e;
    bit hazard;
    hazard = id_vld && ex_vld && ex_mem_ren && ex_reg_wen && (ex_rd != 0) &&
             ((id_rs_use[0] && id_rs1 == ex_rd) || (id_rs_use[1] && id_rs2 == ex_rd));
    {f, h, fl, b, eh, e} = 6'b0;
    case (ms)
      1: if (enable) begin
           if (mem_req && !mem_ack) {h, eh} = 2'b11;
           else if (ex_redirect)    {fl, b} = 2'b11;
           else if (hazard)         {h, b} = 2'b11;
           else                     f = 1'b1;
         end
      2: if (enable) {fl, b} = 2'b11;
      3: if (!mem_ack) {h, eh} = 2'b11;
      4: {e, h, eh} = 3'b111;
      default: ;
    endcase
    return {f, h, fl, b, eh, e, 3'(ms)};
  endfunction

  task automatic model_step();
    logic [8:0] o;
    o = model_out();
    if (o[7] && m_stall < PERF_MAX) m_stall++;
    if (o[6] && m_flushc < PERF_MAX) m_flushc++;
    case (ms)
      0: if (enable) ms = 1;
      1: if (!enable) ms = 0;
         else if (mem_req && !mem_ack) begin ms = 3; m_waited = 0; end
         else if (ex_redirect) begin ms = 2; m_flush_left = FLUSH_CYCLES; end
      2: if (!enable) ms = 0;
         else begin m_flush_left--; if (m_flush_left == 0) ms = 1; end
      3: if (mem_ack) ms = enable ? 1 : 0;
         else begin m_waited++; if (m_waited == MEM_TIMEOUT) ms = 4; end
      4: if (!enable) ms = 0;
      default: ms = 0;
    endcase
  endtask

  task automatic clear_inputs();
    enable = 0; id_vld = 0; ex_vld = 0; ex_mem_ren = 0; ex_reg_wen = 0; ex_redirect = 0;
    mem_req = 0; mem_ack = 0; id_rs1 = '0; id_rs2 = '0; ex_rd = '0; id_rs_use = '0;
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ms = 0; m_flush_left = 0; m_waited = 0; m_stall = 0; m_flushc = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #2;
    n_tests++;
    if (obs !== V_IDLE) begin
      n_fail++; $display("FAIL reset_async got=%b exp=%b", obs, V_IDLE);
    end
    do_reset();
    @(negedge clk);
    n_tests++;
    if (obs !== V_IDLE || stall_cyc !== '0 || flush_cyc !== '0) begin
      n_fail++;
      $display("FAIL reset_idle got=%b/%0d/%0d exp=%b/0/0", obs, stall_cyc, flush_cyc, V_IDLE);
    end
    advance();
  endtask

  task automatic test_enable();
    logic [8:0] exp_v [3] = '{V_IDLE, V_RUN, V_RUN};
    for (int i = 0; i < 3; i++) begin
      enable = 1'b1;
      @(negedge clk);
      n_tests++;
      if (obs !== exp_v[i]) begin
        n_fail++; $display("FAIL enable cyc=%0d got=%b exp=%b", i, obs, exp_v[i]);
      end
      advance();
    end
  endtask

  task automatic test_load_use();
    // {ex_vld, ex_rd, id_rs1, id_rs2, id_rs_use}
    logic       t_exv [7] = '{1, 0, 1, 1, 1, 1, 1};
    logic [4:0] t_rd  [7] = '{5, 5, 0, 5, 5, 9, 9};
    logic [4:0] t_rs1 [7] = '{5, 5, 0, 5, 7, 9, 3};
    logic [4:0] t_rs2 [7] = '{0, 0, 0, 5, 5, 1, 9};
    logic [1:0] t_use [7] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b01};
    logic [8:0] exp_v [7] = '{V_LU, V_RUN, V_RUN, V_RUN, V_LU, V_RUN, V_RUN};
    enable = 1; id_vld = 1; ex_mem_ren = 1; ex_reg_wen = 1;
    for (int i = 0; i < 7; i++) begin
      ex_vld = t_exv[i]; ex_rd = t_rd[i]; id_rs1 = t_rs1[i]; id_rs2 = t_rs2[i]; id_rs_use = t_use[i];
      @(negedge clk);
      n_tests++;
      if (obs !== exp_v[i]) begin
        n_fail++; $display("FAIL load_use cyc=%0d got=%b exp=%b", i, obs, exp_v[i]);
      end
      advance();
    end
    clear_inputs(); enable = 1;
  endtask

  task automatic test_redirect();
    logic       t_red [5] = '{1, 1, 1, 0, 0};
    logic [8:0] exp_v [5] = '{V_REDIR, V_FLUSH, V_FLUSH, V_RUN, V_RUN};
    for (int i = 0; i < 5; i++) begin
      enable = 1; ex_redirect = t_red[i];
      @(negedge clk);
      n_tests++;
      if (obs !== exp_v[i]) begin
        n_fail++; $display("FAIL redirect cyc=%0d got=%b exp=%b", i, obs, exp_v[i]);
      end
      advance();
    end
    ex_redirect = 0;
  endtask

  task automatic test_mem_wait();
    logic t_en  [14] = '{1, 1, 1, 1, 1,  1, 1, 0, 0, 0, 1,  1, 1, 1};
    logic t_req [14] = '{1, 1, 1, 1, 0,  1, 1, 1, 1, 0, 0,  0, 1, 0};
    logic t_ack [14] = '{0, 0, 0, 1, 0,  0, 0, 0, 1, 0, 0,  0, 1, 0};
    logic [8:0] exp_v [14] = '{V_MEMREQ, V_WAIT, V_WAIT, V_WAIT_ACK, V_RUN,
                               V_MEMREQ, V_WAIT, V_WAIT, V_WAIT_ACK, V_IDLE, V_IDLE,
                               V_RUN, V_RUN, V_RUN};
    for (int i = 0; i < 14; i++) begin
      enable = t_en[i]; mem_req = t_req[i]; mem_ack = t_ack[i];
      @(negedge clk);
      n_tests++;
      if (obs !== exp_v[i]) begin
        n_fail++; $display("FAIL mem_wait cyc=%0d got=%b exp=%b", i, obs, exp_v[i]);
      end
      advance();
    end
    clear_inputs(); enable = 1;
  endtask

  task automatic test_timeout();
    logic [8:0] e, m;
    for (int i = 0; i < 16; i++) begin
      enable = !(i == 12 || i == 13);
      mem_req = (i <= 8);
      mem_ack = 0;
      m = 9'h1FF;
      if (i == 0) e = V_MEMREQ;
      else if (i <= 8) e = V_WAIT;
      else if (i <= 11) e = V_ERR;
      else if (i == 12) begin e = V_ERR; m = 9'b000000_111; end
      else if (i <= 14) e = V_IDLE;
      else e = V_RUN;
      @(negedge clk);
      n_tests++;
      if ((obs & m) !== (e & m)) begin
        n_fail++; $display("FAIL timeout cyc=%0d got=%b exp=%b", i, obs & m, e & m);
      end
      advance();
    end
    clear_inputs(); enable = 1;
  endtask

  task automatic test_random();
    logic [8:0] e;
    for (int i = 0; i < 3000; i++) begin
      enable      = (ms == 2) ? 1'b1 : ($urandom_range(0, 19) != 0);
      mem_req     = ($urandom_range(0, 99) < 15);
      mem_ack     = (ms == 3) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 3) == 0);
      ex_redirect = ($urandom_range(0, 99) < 8);
      id_vld      = $urandom_range(0, 1);
      ex_vld      = $urandom_range(0, 1);
      ex_mem_ren  = $urandom_range(0, 1);
      ex_reg_wen  = $urandom_range(0, 1);
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      ex_rd       = 5'($urandom_range(0, 3));
      id_rs_use   = 2'($urandom_range(0, 3));
      @(negedge clk);
      e = model_out();
      n_tests++;
      if (obs !== e) begin
        n_fail++; $display("FAIL random cyc=%0d got=%b exp=%b", i, obs, e);
      end
`ifdef HAZ_PERF_CNT_EN
      n_tests++;
      if (int'(stall_cyc) != m_stall || int'(flush_cyc) != m_flushc) begin
        n_fail++;
        $display("FAIL random_perf cyc=%0d got=%0d/%0d exp=%0d/%0d", i, stall_cyc, flush_cyc, m_stall, m_flushc);
      end
`endif
      advance();
    end
    clear_inputs();
  endtask

`ifdef HAZ_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    enable = 1; advance();                     // IDLE -> RUN
    id_vld = 1; ex_vld = 1; ex_mem_ren = 1; ex_reg_wen = 1; ex_rd = 5; id_rs1 = 5; id_rs_use = 2'b01;
    advance();                                 // one load-use stall
    ex_vld = 0; advance();
    ex_redirect = 1; advance();                // redirect cycle
    ex_redirect = 0; repeat (3) advance();     // two flush cycles, then RUN
    @(negedge clk);
    n_tests++;
    if (stall_cyc !== 2'd1 || flush_cyc !== 2'd3) begin
      n_fail++; $display("FAIL perf_counts got=%0d/%0d exp=1/3", stall_cyc, flush_cyc);
    end
    ex_vld = 1; repeat (5) advance();          // five consecutive stalls
    @(negedge clk);
    n_tests++;
    if (stall_cyc !== 2'd3) begin
      n_fail++; $display("FAIL perf_saturate got=%0d exp=3", stall_cyc);
    end
    clear_inputs();
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_enable();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_timeout();
    test_random();
`ifdef HAZ_PERF_CNT_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
